// File: rtl/operand_seq.sv
// operand_seq: two-operand entry sequencer driving a byte-router select and an ALU valid/ready handshake.
// Build macro OPSEQ_CHAIN_EN: a completed handshake loads alu_result into opnd_a and resumes at ENTER_B.
module operand_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_in,
  input  logic        key_stb,
  input  logic [1:0]  op_code,
  input  logic        op_stb,
  input  logic        clr,
  input  logic        alu_ready,
  input  logic [7:0]  alu_result,
  output logic        memo,
  output logic [7:0]  opnd_a,
  output logic [7:0]  opnd_b,
  output logic [1:0]  op_out,
  output logic        alu_valid,
  output logic        err
);
  typedef enum logic [1:0] {ENTER_A, ENTER_B, ISSUE} state_t;
  state_t     state_q;
  logic       memo_q, valid_q, err_q;
  logic [7:0] a_q, b_q;
  logic [1:0] op_q;
`ifndef OPSEQ_CHAIN_EN
  logic unused_alu_result;
  assign unused_alu_result = ^alu_result;
`endif
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= ENTER_A;
      memo_q  <= 1'b0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      op_q    <= 2'b00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (op_stb) op_q <= op_code;
          if (key_stb) begin
            a_q     <= bus_in[15:8];
            memo_q  <= 1'b1;
            state_q <= ENTER_B;
          end
        end
        ENTER_B: begin
          if (op_stb) op_q <= op_code;
          if (key_stb) begin
            b_q     <= bus_in[7:0];
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // a strobe here would overwrite operands the ALU is still reading
          if (key_stb) err_q <= 1'b1;
          if (alu_ready) begin
            valid_q <= 1'b0;
`ifdef OPSEQ_CHAIN_EN
            a_q     <= alu_result;
            state_q <= ENTER_B;
`else
            memo_q  <= 1'b0;
            state_q <= ENTER_A;
`endif
          end
        end
        default: begin
          state_q <= ENTER_A;
          memo_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
  assign memo      = memo_q;
  assign opnd_a    = a_q;
  assign opnd_b    = b_q;
  assign op_out    = op_q;
  assign alu_valid = valid_q;
  assign err       = err_q;
endmodule
